// File: rtl/mf2_pkg.sv
// rtl/mf2_pkg.sv - shared types and constants for the Multiface-style freezer controller
package mf2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACTIVE
  } mf2_state_e;

  // I/O port high bytes whose writes are shadowed into freezer RAM
  localparam logic [7:0] IO_GA       = 8'h7F;
  localparam logic [7:0] IO_CRTC_SEL = 8'hBC;
  localparam logic [7:0] IO_CRTC_DAT = 8'hBD;
  localparam logic [7:0] IO_PPI      = 8'hF7;
  localparam logic [7:0] IO_ROMSEL   = 8'hDF;

  localparam logic [12:0] OFF_PEN_SEL   = 13'h1FCF;
  localparam logic [12:0] OFF_BORDER    = 13'h1FDF;
  localparam logic [8:0]  OFF_PEN_BASE  = 9'h1F9;
  localparam logic [12:0] OFF_MODE      = 13'h1FEF;
  localparam logic [12:0] OFF_MMR       = 13'h1FFF;
  localparam logic [12:0] OFF_CRTC_SEL  = 13'h1CFF;
  localparam logic [8:0]  OFF_CRTC_BASE = 9'h1DB;
  localparam logic [12:0] OFF_PPI       = 13'h17FF;
  localparam logic [12:0] OFF_ROMSEL    = 13'h1AAC;

  // cpu_addr bit selecting page-out (1) or page-in (0) on the page port
  localparam int PAGE_DIR_BIT = 1;

  function automatic logic [12:0] ga_offset(input logic [1:0] fn, input logic [4:0] pen);
    logic [12:0] off;
    off = OFF_MMR;
    case (fn)
      2'b00: off = OFF_PEN_SEL;
      2'b01: off = pen[4] ? OFF_BORDER : {OFF_PEN_BASE, pen[3:0]};
      2'b10: off = OFF_MODE;
      default: off = OFF_MMR;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/mf2_freezer_ctrl_if.sv
// rtl/mf2_freezer_ctrl_if.sv - CPU bus side of the freezer controller
interface mf2_freezer_ctrl_if;
  logic [15:0] cpu_addr;
  logic        m1;
  logic        io_wr;
  logic [7:0]  io_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        nmi;
  logic        mf_en;
  logic        mf_rom_en;
  logic        mf_ram_en;
  logic [7:0]  mf_ram_dout;

  modport master (
    output cpu_addr, m1, io_wr, io_dout, mem_wr, mem_din,
    input  nmi, mf_en, mf_rom_en, mf_ram_en, mf_ram_dout
  );

  modport slave (
    input  cpu_addr, m1, io_wr, io_dout, mem_wr, mem_din,
    output nmi, mf_en, mf_rom_en, mf_ram_en, mf_ram_dout
  );
endinterface

// File: rtl/mf2_shadow_ram.sv
// rtl/mf2_shadow_ram.sv - single-port freezer RAM, synchronous write-first read
module mf2_shadow_ram #(
  parameter int RAM_AW = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<RAM_AW)-1];

  // Contents deliberately survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (we) rdata <= wdata;
    else         rdata <= mem[addr];
  end

endmodule

// File: rtl/mf2_freezer_ctrl.sv
// rtl/mf2_freezer_ctrl.sv - freezer NMI/paging FSM, hardware-register shadowing and hold-off
module mf2_freezer_ctrl
  import mf2_pkg::*;
#(
  parameter int          RAM_AW    = 13,
  parameter logic [15:0] NMI_VEC   = 16'h0066,
  parameter logic [15:0] HIDE_VEC  = 16'h0065,
  parameter logic [13:0] PAGE_PORT = 14'h3FBA,
  parameter logic [15:0] HOLDOFF   = 16'd4096
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             soft_reset,
  input  logic             key_nmi,
  mf2_freezer_ctrl_if.slave bus
);

  mf2_state_e state, state_nxt;
  logic        hidden, hidden_nxt;
  logic        nmi_q, mf_en_q;
  logic        key_q, m1_q, io_wr_q;
  logic [15:0] holdoff;
  logic [4:0]  pen;
  logic [3:0]  crtc;

  logic        key_rise, m1_rise, wr_rise;
  logic        port_hit, page_in, page_out;
  logic        store_hit, store;
  logic [12:0] store_off;
  logic        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]  ram_wdata, ram_q;

  assign key_rise = key_nmi & ~key_q;
  assign m1_rise  = bus.m1 & ~m1_q;
  assign wr_rise  = bus.io_wr & ~io_wr_q;

  assign port_hit = wr_rise && (bus.cpu_addr[15:2] == PAGE_PORT);
  assign page_out = port_hit &  bus.cpu_addr[PAGE_DIR_BIT];
  assign page_in  = port_hit & ~bus.cpu_addr[PAGE_DIR_BIT];

  assign bus.nmi       = nmi_q;
  assign bus.mf_en     = mf_en_q;
  assign bus.mf_rom_en = mf_en_q && (bus.cpu_addr[15:13] == 3'b000);
  assign bus.mf_ram_en = mf_en_q && (bus.cpu_addr[15:13] == 3'b001);
  assign bus.mf_ram_dout = ram_q;

  always_comb begin
    state_nxt  = state;
    hidden_nxt = hidden;
    if (soft_reset) begin
      state_nxt  = IDLE;
      hidden_nxt = 1'b0;
    end else if (page_out) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (page_in && !hidden)                state_nxt = ACTIVE;
          else if (key_rise && holdoff == 16'd0) state_nxt = PEND;
        end
        PEND: begin
          if (m1_rise && bus.cpu_addr == NMI_VEC) begin
            state_nxt  = ACTIVE;
            hidden_nxt = 1'b0;
          end
        end
        ACTIVE: begin
          if (m1_rise && bus.cpu_addr == HIDE_VEC) hidden_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      hidden  <= 1'b0;
      nmi_q   <= 1'b0;
      mf_en_q <= 1'b0;
      key_q   <= 1'b0;
      m1_q    <= 1'b0;
      io_wr_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      hidden  <= hidden_nxt;
      nmi_q   <= (state_nxt == PEND);
      mf_en_q <= (state_nxt == ACTIVE);
      key_q   <= key_nmi;
      m1_q    <= bus.m1;
      io_wr_q <= bus.io_wr;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                 holdoff <= '0;
    else if (soft_reset)          holdoff <= '0;
    else if (page_out)            holdoff <= HOLDOFF;
    else if (holdoff != 16'd0)    holdoff <= holdoff - 16'd1;
  end

  always_comb begin
    store_hit = 1'b1;
    store_off = OFF_MMR;
    case (bus.cpu_addr[15:8])
      IO_GA:       store_off = ga_offset(bus.io_dout[7:6], pen);
      IO_CRTC_SEL: store_off = OFF_CRTC_SEL;
      IO_CRTC_DAT: store_off = {OFF_CRTC_BASE, crtc};
      IO_PPI:      store_off = OFF_PPI;
      IO_ROMSEL:   store_off = OFF_ROMSEL;
      default:     store_hit = 1'b0;
    endcase
  end

  assign store = wr_rise & ~port_hit & store_hit;

  // Index registers track the selects so later data writes land in the right slot.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pen  <= '0;
      crtc <= '0;
    end else if (soft_reset) begin
      pen  <= '0;
      crtc <= '0;
    end else if (store) begin
      if (bus.cpu_addr[15:8] == IO_GA && bus.io_dout[7:6] == 2'b00) pen <= bus.io_dout[4:0];
      if (bus.cpu_addr[15:8] == IO_CRTC_SEL)                         crtc <= bus.io_dout[3:0];
    end
  end

  // Single RAM port: shadow store beats a CPU write, which beats a plain read.
  always_comb begin
    ram_addr  = '1;
    ram_we    = 1'b0;
    ram_wdata = bus.mem_din;
    if (store) begin
      ram_addr[12:0] = store_off;
      ram_we         = 1'b1;
      ram_wdata      = bus.io_dout;
    end else begin
      ram_addr[12:0] = bus.cpu_addr[12:0];
      ram_we         = bus.mem_wr & bus.mf_ram_en;
    end
  end

  mf2_shadow_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_mf2_freezer_ctrl.sv
// tb/tb_mf2_freezer_ctrl.sv - directed self-checking bench for mf2_freezer_ctrl
module tb_mf2_freezer_ctrl;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic soft_reset;
  logic key_nmi;
  int   checks = 0;
  int   failures = 0;

  mf2_freezer_ctrl_if bus();

  mf2_freezer_ctrl #(
    .RAM_AW    (14),
    .NMI_VEC   (16'h0066),
    .HIDE_VEC  (16'h0065),
    .PAGE_PORT (14'h3FBA),
    .HOLDOFF   (16'd16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .soft_reset (soft_reset),
    .key_nmi    (key_nmi),
    .bus        (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr = a;
    bus.io_dout  = d;
    bus.io_wr    = 1'b1;
    step();
    bus.io_wr = 1'b0;
    step();
  endtask

  task automatic m1_fetch(input logic [15:0] a);
    bus.cpu_addr = a;
    bus.m1       = 1'b1;
    step();
    bus.m1 = 1'b0;
    step();
  endtask

  task automatic ram_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus.cpu_addr = a;
    step();
    chk(tag, {8'h00, bus.mf_ram_dout}, {8'h00, exp});
  endtask

  initial begin
    reset_n      = 1'b0;
    soft_reset   = 1'b0;
    key_nmi      = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.m1       = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_dout  = 8'h00;
    bus.mem_wr   = 1'b0;
    bus.mem_din  = 8'h00;
    step();
    step();
    chk("rst_nmi", {15'd0, bus.nmi}, 16'd0);
    chk("rst_mf_en", {15'd0, bus.mf_en}, 16'd0);
    chk("rst_dout", {8'h00, bus.mf_ram_dout}, 16'h0000);
    reset_n = 1'b1;
    step();
    chk("idle_nmi", {15'd0, bus.nmi}, 16'd0);

    // key press -> NMI, wrong M1 address keeps PEND, vector fetch pages in
    key_nmi = 1'b1;
    step();
    chk("key_nmi", {15'd0, bus.nmi}, 16'd1);
    chk("pend_mf_en", {15'd0, bus.mf_en}, 16'd0);
    key_nmi = 1'b0;
    m1_fetch(16'h0067);
    chk("m1_0067_nmi", {15'd0, bus.nmi}, 16'd1);
    chk("m1_0067_en", {15'd0, bus.mf_en}, 16'd0);
    m1_fetch(16'h0066);
    chk("m1_0066_nmi", {15'd0, bus.nmi}, 16'd0);
    chk("m1_0066_en", {15'd0, bus.mf_en}, 16'd1);
    bus.cpu_addr = 16'h0100;
    #1;
    chk("rom_en_0100", {14'd0, bus.mf_rom_en, bus.mf_ram_en}, 16'b10);
    bus.cpu_addr = 16'h1FFF;
    #1;
    chk("rom_en_1fff", {14'd0, bus.mf_rom_en, bus.mf_ram_en}, 16'b10);
    bus.cpu_addr = 16'h2000;
    #1;
    chk("ram_en_2000", {14'd0, bus.mf_rom_en, bus.mf_ram_en}, 16'b01);
    bus.cpu_addr = 16'h4000;
    #1;
    chk("none_4000", {14'd0, bus.mf_rom_en, bus.mf_ram_en}, 16'b00);

    // key edges ignored while paged in
    key_nmi = 1'b1;
    step();
    chk("active_key", {14'd0, bus.nmi, bus.mf_en}, 16'b01);
    key_nmi = 1'b0;

    // shadow stores
    io_write(16'hBC00, 8'h05);
    io_write(16'hBD00, 8'h3F);
    io_write(16'h7F00, 8'h10);
    io_write(16'h7F00, 8'h54);
    io_write(16'h7F00, 8'h03);
    io_write(16'h7F00, 8'h4A);
    io_write(16'hF700, 8'h82);
    io_write(16'hDF00, 8'h07);
    io_write(16'h7F00, 8'hC4);
    ram_read("sh_1cff", 16'h3CFF, 8'h05);
    ram_read("sh_1db5", 16'h3DB5, 8'h3F);
    ram_read("sh_1fdf", 16'h3FDF, 8'h54);
    ram_read("sh_1fcf", 16'h3FCF, 8'h03);
    ram_read("sh_1f93", 16'h3F93, 8'h4A);
    ram_read("sh_17ff", 16'h37FF, 8'h82);
    ram_read("sh_1aac", 16'h3AAC, 8'h07);
    ram_read("sh_1fff", 16'h3FFF, 8'hC4);

    // CPU write to freezer RAM, write-first then registered read
    bus.cpu_addr = 16'h2123;
    bus.mem_din  = 8'hA5;
    bus.mem_wr   = 1'b1;
    #1;
    chk("wr_en", {14'd0, bus.mf_rom_en, bus.mf_ram_en}, 16'b01);
    step();
    bus.mem_wr = 1'b0;
    chk("wr_first", {8'h00, bus.mf_ram_dout}, 16'h00A5);
    ram_read("rd_2123", 16'h2123, 8'hA5);

    // page out; edge p
    bus.cpu_addr = 16'hFEEA;
    bus.io_wr    = 1'b1;
    step();
    chk("page_out", {14'd0, bus.nmi, bus.mf_en}, 16'b00);
    bus.io_wr    = 1'b0;
    bus.cpu_addr = 16'h2123;
    bus.mem_din  = 8'h5A;
    bus.mem_wr   = 1'b1;
    step();                                   // p+1: write dropped, paged out
    bus.mem_wr = 1'b0;
    key_nmi    = 1'b1;
    step();                                   // p+2
    chk("holdoff_early", {15'd0, bus.nmi}, 16'd0);
    key_nmi = 1'b0;
    step();                                   // p+3
    repeat (12) step();                       // p+15
    key_nmi = 1'b1;
    step();                                   // p+16: one cycle of hold-off left
    chk("holdoff_last", {15'd0, bus.nmi}, 16'd0);
    key_nmi = 1'b0;
    step();                                   // p+17
    key_nmi = 1'b1;
    step();                                   // p+18
    chk("holdoff_done", {15'd0, bus.nmi}, 16'd1);
    key_nmi = 1'b0;

    // soft reset in PEND
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    chk("soft_rst", {14'd0, bus.nmi, bus.mf_en}, 16'b00);
    io_write(16'hFEE8, 8'h00);
    chk("page_in", {15'd0, bus.mf_en}, 16'd1);
    ram_read("dropped_wr", 16'h2123, 8'hA5);

    // hidden blocks a later software page-in
    m1_fetch(16'h0065);
    io_write(16'hFEEA, 8'h00);
    chk("hide_out", {15'd0, bus.mf_en}, 16'd0);
    io_write(16'hFEE8, 8'h00);
    chk("hidden_in", {15'd0, bus.mf_en}, 16'd0);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    io_write(16'hFEE8, 8'h00);
    chk("unhide_in", {15'd0, bus.mf_en}, 16'd1);

    // async reset mid-cycle clears outputs at once, RAM contents kept
    ram_read("pre_rst", 16'h2123, 8'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {3'd0, bus.nmi, bus.mf_en, bus.mf_rom_en, bus.mf_ram_en, 1'b0, bus.mf_ram_dout},
        16'h0000);
    step();
    reset_n = 1'b1;
    io_write(16'hFEE8, 8'h00);
    ram_read("ram_kept", 16'h2123, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
